neuron_config_loader: RTL
=========================

# neuron_config_loader

Initiator for the neuron weight/bias configuration bus. It accepts a flat stream of 32-bit words from the host or DMA side over a valid/ready handshake. It sequences each word onto `weightValid`/`biasValid` with the matching `config_layer_num`/`config_neuron_num`, walking every neuron of every layer in order. It sits between the host interface and the fan-out to all neuron instances; each neuron self-selects on the layer/neuron match.

## Interface
Parameters:
- `numLayers`, 4, number of layers to configure (1..8).
- `layerNeurons`, {8'd10,8'd10,8'd30,8'd30}, packed neuron count per layer; layer i at `[8*i +: 8]`; each field ≥1.
- `layerWeights`, {16'd10,16'd30,16'd30,16'd784}, packed weights per neuron for each layer; layer i at `[16*i +: 16]`; each field ≥1.

Ports:
- `clk` input 1: the only clock.
- `rst` input 1: synchronous, active-low reset.
- `start` input 1: single-cycle request to begin a full load.
- `s_data` input 32: host word.
- `s_valid` input 1: host word valid.
- `s_ready` output 1: loader accepts a word this cycle.
- `weightValid` output 1: one-cycle weight write strobe.
- `biasValid` output 1: one-cycle bias write strobe.
- `weightValue` output 32: weight word.
- `biasValue` output 32: bias word.
- `config_layer_num` output 32: target layer, zero-extended.
- `config_neuron_num` output 32: target neuron within the layer, zero-extended.
- `busy` output 1: load in progress.
- `done` output 1: one-cycle pulse after the last bias is issued.

## Operation
- Word order per neuron: `layerWeights[l]` weights, then 1 bias. Neurons go 0..N-1 within a layer; layers go 0..numLayers-1.
- Total accepted words per load: Σ layerNeurons[l]·(layerWeights[l]+1).
- States:
  - IDLE: `start`=1 → WEIGHT; counters w=n=l=0.
  - WEIGHT: on accept, w++. At w=layerWeights[l]-1 the accept goes to BIAS and clears w.
  - BIAS: on accept, the next state depends on position:
    - If n<layerNeurons[l]-1: n++ and go to WEIGHT.
    - Else if l<numLayers-1: n=0, l++ and go to WEIGHT.
    - Else go to DONE.
  - DONE: one cycle, `done`=1, then go to IDLE.
- `s_ready` = 1 exactly in WEIGHT or BIAS. It is a combinational decode of the state register and has no dependence on `s_valid`.
- Accept = `s_valid & s_ready`. With no accept, state and counters hold and both strobes are low the next cycle.
- Output registers on accept in WEIGHT:
  - `weightValue` ← `s_data`, `weightValid` ← 1.
  - `config_layer_num` ← l, `config_neuron_num` ← n.
- Output registers on accept in BIAS: same as WEIGHT, but using `biasValue` and `biasValid`.
- The layer/neuron numbers always change in the same cycle as their strobe, never before. Neurons compare them combinationally against the strobe.
- Value and number registers hold their last value when no strobe is active.
- `weightValid` and `biasValid` are never high together.
- `start` outside IDLE is ignored. `s_valid` in IDLE or DONE is ignored, and the word is not consumed.
- `busy` = state ≠ IDLE.

## Timing
- Reset (`rst`=0 at a clock edge) drives the state to IDLE. All outputs are 0: `s_ready`, both strobes, both values, both config numbers, `busy`, `done`.
- Reset mid-load aborts immediately; there is no completion `done`. The next `start` restarts at layer 0, neuron 0, weight 0. A neuron must also be reset to realign its write pointer.
- Latency: an accept at edge k produces its strobe during cycle k+1. Sustained `s_valid`=1 gives one strobe per cycle with no bubbles, including across weight→bias, neuron, and layer boundaries.
- `start` at edge k makes `s_ready`=1 in cycle k+1.
- The final bias is accepted at edge k, giving `biasValid`=1 and `done`=1 together in cycle k+1; `s_ready`=0 from cycle k+1. The state is back in IDLE in cycle k+2.
- Back-to-back loads: `start` may be asserted in the DONE cycle only if it is held until IDLE. A `start` during DONE itself is ignored.

## Structure
- Shared package/include: the state encoding (IDLE, WEIGHT, BIAS, DONE) as localparams. Add `cfgWordWidth`=32 to `include.v`.
- Counter widths: w=16, n=8, l=3 bits. Compute the per-layer limits by indexing the packed parameters with l.
- No sub-module is needed; a single module with the FSM and three counters.

## Test plan
Default test parameters: numLayers=2, layerNeurons={8'd2,8'd3}, layerWeights={16'd3,16'd4}, giving 23 words.

1. Reset and idle: hold `rst`=0 for 3 cycles, then drive `s_valid`=1 with no `start` → all outputs stay 0 and `s_ready`=0.
2. Full streaming load: `start`, then 23 consecutive words 0..22 with `s_valid`=1.
   - Required sequence: W(0,0)=0..3, B(0,0)=4, W(0,1)=5..8, B(0,1)=9, …, B(1,1)=22.
   - `done`=1 in the same cycle as the bias 22 strobe, and no gaps between strobes.
3. Throttled source: random `s_valid` at 50% duty → same strobe sequence as scenario 2, with a strobe only in the cycle after each accept.
4. Reset at word 7 (layer 0, neuron 1, weight 2), then `start` and 23 words → strobes restart at W(0,0) and there is no `done` before the restart.
5. `start` pulses asserted during a load are ignored: the sequence is unchanged and only one `done` occurs.
6. Single-element config (numLayers=1, layerNeurons=1, layerWeights=1): 2 words → one `weightValid` then one `biasValid`, both at (0,0), with `done` on the bias cycle.

Source files
------------

// File: rtl/neuron_config_loader_pkg.sv
// Shared definitions for the neuron configuration loader.
// Holds the configuration word width and the loader FSM state encoding.
package neuron_config_loader_pkg;

  localparam int cfgWordWidth = 32;

  // Loader FSM states
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WEIGHT = 2'd1;
  localparam logic [1:0] BIAS   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

endpackage

// File: rtl/neuron_config_loader.sv
// neuron_config_loader: initiator for the neuron weight/bias configuration bus.
// Takes a flat stream of words over a valid/ready handshake and issues each one
// as a weight or bias write strobe tagged with its target layer and neuron,
// walking every weight of every neuron of every layer in order.
//
// Ports:
//   clk               - clock
//   rst               - synchronous active-low reset
//   start             - single-cycle request to begin a full load (IDLE only)
//   s_data / s_valid  - host word and its valid
//   s_ready           - loader accepts a word this cycle (WEIGHT or BIAS)
//   weightValid/Value - one-cycle weight strobe and registered weight word
//   biasValid/Value   - one-cycle bias strobe and registered bias word
//   config_layer_num  - target layer of the current strobe, zero-extended
//   config_neuron_num - target neuron of the current strobe, zero-extended
//   busy              - load in progress
//   done              - one-cycle pulse together with the final bias strobe
module neuron_config_loader
  import neuron_config_loader_pkg::*;
#(
  parameter int                      numLayers    = 4,
  parameter logic [8*numLayers-1:0]  layerNeurons = {8'd10, 8'd10, 8'd30, 8'd30},
  parameter logic [16*numLayers-1:0] layerWeights = {16'd10, 16'd30, 16'd30, 16'd784}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [cfgWordWidth-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    weightValid,
  output logic                    biasValid,
  output logic [cfgWordWidth-1:0] weightValue,
  output logic [cfgWordWidth-1:0] biasValue,
  output logic [31:0]             config_layer_num,
  output logic [31:0]             config_neuron_num,
  output logic                    busy,
  output logic                    done
);

  localparam logic [2:0] LAST_LAYER = 3'(numLayers - 1);

  logic [1:0]  state;
  logic [15:0] w;
  logic [7:0]  n;
  logic [2:0]  l;
  logic [15:0] w_last;
  logic [7:0]  n_last;
  logic        accept;

  // Per-layer limits selected from the packed parameters by the layer counter.
  always_comb begin
    w_last = 16'(layerWeights >> {l, 4'b0000}) - 16'd1;
    n_last = 8'(layerNeurons >> {l, 3'b000}) - 8'd1;
  end

  assign s_ready = (state == WEIGHT) || (state == BIAS);
  assign accept  = s_valid && s_ready;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      w                 <= '0;
      n                 <= '0;
      l                 <= '0;
      weightValid       <= 1'b0;
      biasValid         <= 1'b0;
      weightValue       <= '0;
      biasValue         <= '0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
    end else begin
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      // Layer/neuron numbers are captured with the word so they change in the
      // same cycle as the strobe that qualifies them.
      if (accept) begin
        config_layer_num  <= 32'(l);
        config_neuron_num <= 32'(n);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= WEIGHT;
            w     <= '0;
            n     <= '0;
            l     <= '0;
          end
        end
        WEIGHT: begin
          if (accept) begin
            weightValid <= 1'b1;
            weightValue <= s_data;
            if (w == w_last) begin
              w     <= '0;
              state <= BIAS;
            end else begin
              w <= w + 16'd1;
            end
          end
        end
        BIAS: begin
          if (accept) begin
            biasValid <= 1'b1;
            biasValue <= s_data;
            if (n != n_last) begin
              n     <= n + 8'd1;
              state <= WEIGHT;
            end else if (l != LAST_LAYER) begin
              n     <= '0;
              l     <= l + 3'd1;
              state <= WEIGHT;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
